// File: rtl/easyaxi_traffic_gen.sv
// AXI4 master traffic generator: NUM_TXN write-then-read-back burst pairs against one slave.
// Build option EASYAXI_TG_CHECK_EN: read-back data/response/rlast checking and error counting.
module easyaxi_traffic_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 4,
  parameter int NUM_TXN    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  input  logic [1:0]              bresp,
  output logic                    bready,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0]            SIZE      = 3'($clog2(BYTES));
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(BURST_LEN * BYTES);
  localparam logic [8:0]            LAST_BEAT = 9'(BURST_LEN - 1);
  localparam logic [15:0]           LAST_TXN  = 16'(NUM_TXN - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE} state_t;

  state_t                state, state_n;
  logic [15:0]           txn;
  logic [8:0]            beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_beat;

  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (enable)               state_n = S_AW;
      S_AW:   if (awready)              state_n = S_W;
      S_W:    if (wready && last_beat)  state_n = S_B;
      S_B:    if (bvalid)               state_n = S_AR;
      S_AR:   if (arready)              state_n = S_R;
      S_R:    if (rvalid && last_beat)  state_n = S_NEXT;
      S_NEXT: begin
        if (txn == LAST_TXN) state_n = S_DONE;
        else if (!enable)    state_n = S_IDLE;
        else                 state_n = S_AW;
      end
      S_DONE: if (!enable)              state_n = S_IDLE;
      default:                          state_n = S_IDLE;
    endcase
  end

  // data_q tracks the expected beat value; it is reloaded at the start of each burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn    <= '0;
      beat   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          txn    <= '0;
          beat   <= '0;
          addr_q <= BASE_ADDR;
        end
        S_AW, S_AR: if ((state == S_AW) ? awready : arready) begin
          beat   <= '0;
          data_q <= DATA_WIDTH'(addr_q);
        end
        S_W, S_R: if ((state == S_W) ? wready : rvalid) begin
          beat   <= last_beat ? 9'd0 : beat + 9'd1;
          data_q <= data_q + DATA_WIDTH'(BYTES);
        end
        S_NEXT: if (txn != LAST_TXN && enable) begin
          txn    <= txn + 16'd1;
          addr_q <= addr_q + STRIDE;
        end
        default: ;
      endcase
    end
  end

  assign done    = (state == S_DONE);
  assign awvalid = (state == S_AW);
  assign wvalid  = (state == S_W);
  assign bready  = (state == S_B);
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);
  assign wlast   = (state == S_W) && last_beat;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = data_q;
  assign wstrb   = '1;
  assign awid    = '0;
  assign arid    = '0;
  assign awlen   = 8'(BURST_LEN - 1);
  assign arlen   = 8'(BURST_LEN - 1);
  assign awsize  = SIZE;
  assign arsize  = SIZE;
  assign awburst = 2'b01;
  assign arburst = 2'b01;

`ifdef EASYAXI_TG_CHECK_EN
  logic        err_inc;
  logic [15:0] err_q;

  always_comb begin
    err_inc = 1'b0;
    if (state == S_B && bvalid && bresp != 2'b00) err_inc = 1'b1;
    if (state == S_R && rvalid &&
        (rdata != data_q || rresp != 2'b00 || rlast != last_beat)) err_inc = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= '0;
    else if (state == S_IDLE && enable)      err_q <= '0;
    else if (err_inc && err_q != 16'hFFFF)   err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
  assign pass    = done && (err_q == 16'd0);
`else
  logic unused_rsp;
  assign unused_rsp = ^{bresp, rdata, rresp, rlast};
  assign err_cnt    = '0;
  assign pass       = done;
`endif

endmodule
